muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer owning the architectural HI/LO pair.

---
 rtl/muldiv_seq_if.sv | 43 ++++
 rtl/muldiv_seq.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
//   Bundle between decode/regfile and the iterative multiply/divide sequencer.
//
//   master (decode side) drives:
//     start    launch a mult/div when the engine is idle
//     op       00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//     a, b     operands; a is also the mthi/mtlo data
//     wr_hi    mthi request
//     wr_lo    mtlo request
//     rd_hilo  mfhi/mflo sitting in decode this cycle
//   slave (sequencer side) drives:
//     hi, lo   architectural HI/LO registers
//     busy     engine iterating or fixing up
//     done     one-cycle pulse after HI/LO are written by an op
//     stall    hold the requester; combinational
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, rd_hilo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, rd_hilo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Radix-2 iterative multiply/divide engine that owns the HI/LO pair.
//   One shift-add (multiply) or restoring-subtract (divide) step per clock,
//   sequenced IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//
//   Ports:
//     i_clk      core clock, all state on posedge
//     i_reset_n  asynchronous active-low reset
//     bus        muldiv_seq_if.slave: start/op/a/b/wr_hi/wr_lo/rd_hilo in,
//                hi/lo/busy/done/stall out
//
//   Build option:
//     MULDIV_SIGNED_EN  when defined, op 10/11 are signed MULT/DIV (magnitudes
//                       captured at start, signs restored in FIX). When
//                       undefined, op[1] is ignored and no negation logic
//                       exists; FIX still takes one cycle.
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  muldiv_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_opb;     // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] r_ph;      // product high / partial remainder
  logic [WIDTH-1:0] r_pl;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  // Multiply step: WIDTH+1 bit accumulator keeps the carry, then {acc, pl} >> 1.
  logic [WIDTH:0]   w_macc;
  assign w_macc = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

  // Divide step: shift next dividend bit into the remainder, trial-subtract.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  assign w_shift = {r_ph, r_pl[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  assign w_ge    = (w_shift >= {1'b0, r_opb});

`ifdef MULDIV_SIGNED_EN
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    return unsigned'(-s);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] s;
    s = signed'(v);
    return unsigned'(-s);
  endfunction

  logic               w_a_neg;
  logic               w_b_neg;
  logic               r_neg_q;   // signs differ: negate product / quotient
  logic               r_neg_r;   // dividend negative: negate remainder
  logic               r_dbz;     // divide by zero: quotient left as all ones
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_a_neg = bus.op[1] & bus.a[WIDTH-1];
  assign w_b_neg = bus.op[1] & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? neg_w(bus.a) : bus.a;
  assign w_b_mag = w_b_neg ? neg_w(bus.b) : bus.b;

  assign w_prod     = {r_ph, r_pl};
  assign w_prod_fix = r_neg_q ? neg_2w(w_prod) : w_prod;
  assign w_q_fix    = (r_neg_q & ~r_dbz) ? neg_w(r_pl) : r_pl;
  // With b==0 the remainder register ends up holding |a|, so restoring the
  // dividend sign yields HI = a exactly.
  assign w_r_fix    = r_neg_r ? neg_w(r_ph) : r_ph;

  assign w_hi_res = r_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_div ? w_q_fix : w_prod_fix[WIDTH-1:0];
`else
  logic w_unused_op1;
  assign w_unused_op1 = bus.op[1];
  assign w_a_mag  = bus.a;
  assign w_b_mag  = bus.b;
  assign w_hi_res = r_ph;
  assign w_lo_res = r_pl;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_opb   <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE: accept a launch, else service mthi/mtlo
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH - 1);
            r_div   <= bus.op[0];
            r_ph    <= '0;
            r_opb   <= bus.op[0] ? w_b_mag : w_a_mag;
            r_pl    <= bus.op[0] ? w_a_mag : w_b_mag;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dbz   <= (bus.b == '0);
`endif
          end else begin
            if (bus.wr_hi) r_hi <= bus.a;
            if (bus.wr_lo) r_lo <= bus.a;
          end
        end
        // RUN: one radix-2 iteration per edge, WIDTH edges total
        S_RUN: begin
          if (r_div) begin
            r_ph <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_pl <= {r_pl[WIDTH-2:0], w_ge};
          end else begin
            r_ph <= w_macc[WIDTH:1];
            r_pl <= {w_macc[0], r_pl[WIDTH-1:1]};
          end
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // FIX: commit (sign-corrected) result to HI/LO
        S_FIX: begin
          r_hi    <= w_hi_res;
          r_lo    <= w_lo_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.stall = r_busy & (bus.start | bus.wr_hi | bus.wr_lo | bus.rd_hilo);

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//   Directed, table-driven bench for muldiv_seq plus hand-written sequences
//   for stall behaviour, back-to-back launch and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        nm;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the launch edge; returns edges until done and the
  // number of sampled cycles with busy high before done.
  task automatic wait_done(output int edges, output int bcnt);
    bcnt  = 0;
    edges = 0;
    if (bus.busy) bcnt++;
    for (int e = 1; e <= 100; e++) begin
      tick();
      edges = e;
      if (bus.done) break;
      if (bus.busy) bcnt++;
    end
    if (!bus.done) edges = 999;
  endtask

  task automatic run_vec(input vec_t v);
    int edges, bcnt;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(edges, bcnt);
    chk({v.nm, " latency"}, W'(edges), W'(W + 1));
    chk({v.nm, " busy_cycles"}, W'(bcnt), W'(W + 1));
    chk1({v.nm, " busy_in_done"}, bus.busy, 1'b0);
    chk({v.nm, " hi"}, bus.hi, v.hi);
    chk({v.nm, " lo"}, bus.lo, v.lo);
    tick();
    chk1({v.nm, " done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int edges, bcnt, ndone;

    tv.push_back('{"multu_7x6",   2'b00, 32'd7,          32'd6,          32'd0,          32'd42});
    tv.push_back('{"multu_max",   2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001});
    tv.push_back('{"multu_shift", 2'b00, 32'h12345678,   32'h00000010,   32'h00000001,   32'h23456780});
    tv.push_back('{"divu_100_7",  2'b01, 32'd100,        32'd7,          32'd2,          32'd14});
    tv.push_back('{"divu_5_0",    2'b01, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF});
    tv.push_back('{"divu_max_16", 2'b01, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F,   32'h0FFFFFFF});
`ifdef MULDIV_SIGNED_EN
    tv.push_back('{"div_m7_2",    2'b11, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD});
    tv.push_back('{"div_7_m2",    2'b11, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD});
    tv.push_back('{"mult_m3_5",   2'b10, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1});
    tv.push_back('{"div_ovf",     2'b11, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000});
    tv.push_back('{"div_m5_0",    2'b11, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   32'hFFFFFFFF});
`else
    tv.push_back('{"op3_unsigned", 2'b11, 32'hFFFFFFF9,  32'd2,          32'd1,          32'h7FFFFFFC});
    tv.push_back('{"op2_unsigned", 2'b10, 32'hFFFFFFFD,  32'd5,          32'd4,          32'hFFFFFFF1});
    tv.push_back('{"divu_big",     2'b01, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0});
`endif

    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.rd_hilo = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst hi", bus.hi, '0);
    chk("rst lo", bus.lo, '0);
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst done", bus.done, 1'b0);
    chk1("rst stall", bus.stall, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // Table of operations
    foreach (tv[i]) run_vec(tv[i]);

    // mthi+mtlo together in IDLE, rd_hilo does not stall when idle
    bus.a = 32'hDEADBEEF; bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.rd_hilo = 1'b1;
    #1 chk1("idle stall", bus.stall, 1'b0);
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.rd_hilo = 1'b0;
    chk("mthi_mtlo hi", bus.hi, 32'hDEADBEEF);
    chk("mthi_mtlo lo", bus.lo, 32'hDEADBEEF);
    bus.a = 32'h00001234; bus.wr_hi = 1'b1;
    tick();
    bus.wr_hi = 1'b0;
    chk("mthi hi", bus.hi, 32'h00001234);
    chk("mthi lo_kept", bus.lo, 32'hDEADBEEF);

    // start wins over mtlo in the same idle cycle
    bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1; bus.wr_lo = 1'b1;
    tick();
    bus.start = 1'b0; bus.wr_lo = 1'b0;
    chk("start_prio lo_kept", bus.lo, 32'hDEADBEEF);
    chk1("start_prio busy", bus.busy, 1'b1);
    wait_done(edges, bcnt);
    chk("start_prio latency", W'(edges), W'(W + 1));
    chk("start_prio lo", bus.lo, 32'd42);
    chk("start_prio hi", bus.hi, 32'd0);
    tick();

    // Requests while busy are stalled and ignored; start held into the done
    // cycle is accepted there
    bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
    tick();
    bus.op = 2'b01; bus.a = 32'd100; bus.b = 32'd7;
    bus.wr_hi = 1'b1; bus.rd_hilo = 1'b1;
    ndone = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.done) begin
        ndone = 1;
        break;
      end
      chk1("busy stall", bus.stall, 1'b1);
      chk("busy hi_kept", bus.hi, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("b2b first_done", W'(ndone), W'(1));
    chk("b2b first hi", bus.hi, 32'd0);
    chk("b2b first lo", bus.lo, 32'd42);
    chk1("b2b done_cycle stall", bus.stall, 1'b0);
    tick();
    bus.start = 1'b0; bus.wr_hi = 1'b0; bus.rd_hilo = 1'b0;
    chk1("b2b accepted busy", bus.busy, 1'b1);
    wait_done(edges, bcnt);
    chk("b2b second latency", W'(edges), W'(W + 1));
    chk("b2b second hi", bus.hi, 32'd2);
    chk("b2b second lo", bus.lo, 32'd14);
    tick();

    // Asynchronous reset in the middle of RUN
    bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk1("pre_rst busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst busy", bus.busy, 1'b0);
    chk1("midrst done", bus.done, 1'b0);
    chk("midrst hi", bus.hi, '0);
    chk("midrst lo", bus.lo, '0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    bus.a = 32'd9; bus.wr_lo = 1'b1;
    #1 chk1("post_rst stall", bus.stall, 1'b0);
    tick();
    bus.wr_lo = 1'b0;
    chk("post_rst lo", bus.lo, 32'd9);
    chk("post_rst hi", bus.hi, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) ndone++;
      tick();
    end
    chk("post_rst no_activity", W'(ndone), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
